baccarat_hand_bank: RTL and testbench

- Parametrised successor to the fixed two-hand, six-card baccarat datapath.
- Holds NUM_HANDS hands of CARDS_PER_HAND card slots each.
- Deals cards from a free-running 1..13 counter, or from a bench-forced value, on a detected key press.
- Produces a mod-10 score per hand and a 7-segment code per slot.
- Sits between the dealing FSM (which drives load_en, load_hand and load_slot) and the board HEX drivers / win logic.

---
 rtl/baccarat_hand_bank.sv | 127 ++++++++++++
 tb/tb_baccarat_hand_bank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_hand_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// baccarat_hand_bank : NUM_HANDS x CARDS_PER_HAND card bank, deal counter,
// mod-10 hand scores and active-low 7-segment codes per slot.  Rev 1.0
// ---------------------------------------------------------------------------
module baccarat_hand_bank #(
  parameter int NUM_HANDS      = 2,
  parameter int CARDS_PER_HAND = 3,
  parameter int HW             = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  parameter int SW             = (CARDS_PER_HAND > 1) ? $clog2(CARDS_PER_HAND) : 1
) (
  input  logic                                  clk,
  input  logic                                  resetb,
  input  logic                                  key,
  input  logic                                  load_en,
  input  logic [HW-1:0]                         load_hand,
  input  logic [SW-1:0]                         load_slot,
  input  logic                                  force_en,
  input  logic [3:0]                            force_card,
  output logic [4*NUM_HANDS*CARDS_PER_HAND-1:0] cards_out,
  output logic [4*NUM_HANDS-1:0]                scores_out,
  output logic [NUM_HANDS-1:0]                  hand_full,
  output logic [7*NUM_HANDS*CARDS_PER_HAND-1:0] hex_out,
  output logic                                  load_err
);

  localparam int c_SLOTS = NUM_HANDS * CARDS_PER_HAND;

  logic [3:0]         r_cards [c_SLOTS];
  logic [3:0]         r_deal;
  logic               r_key_hist;
  logic               r_load_err;

  logic               w_press;
  logic               w_hand_ok;
  logic               w_slot_ok;
  logic               w_force_bad;
  logic               w_occupied;
  logic               w_reject;
  logic               w_write;
  logic [3:0]         w_val;
  logic [c_SLOTS-1:0] w_hit;

  function automatic logic [3:0] f_points(input logic [3:0] card);
    return (card >= 4'd1 && card <= 4'd9) ? card : 4'd0;
  endfunction

  function automatic logic [6:0] f_hex(input logic [3:0] card);
    case (card)
      4'd1:    return 7'b0001000;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      4'd10:   return 7'b1000000;
      4'd11:   return 7'b1100001;
      4'd12:   return 7'b0011000;
      4'd13:   return 7'b0001001;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_press     = r_key_hist & ~key;
  // One extra bit so NUM_HANDS / CARDS_PER_HAND never truncate when they are a power of two
  assign w_hand_ok   = {1'b0, load_hand} < (HW+1)'(NUM_HANDS);
  assign w_slot_ok   = {1'b0, load_slot} < (SW+1)'(CARDS_PER_HAND);
  assign w_force_bad = force_en & ((force_card == 4'd0) | (force_card > 4'd13));
  assign w_val       = force_en ? force_card : r_deal;

  always_comb begin
    w_hit      = '0;
    w_occupied = 1'b0;
    for (int i = 0; i < c_SLOTS; i++) begin
      w_hit[i]   = w_hand_ok && w_slot_ok &&
                   (load_hand == HW'(i / CARDS_PER_HAND)) &&
                   (load_slot == SW'(i % CARDS_PER_HAND));
      w_occupied = w_occupied | (w_hit[i] & (r_cards[i] != 4'd0));
    end
  end

  assign w_reject = w_press & load_en & (~w_hand_ok | ~w_slot_ok | w_occupied | w_force_bad);
  assign w_write  = w_press & load_en & ~w_reject;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_deal     <= 4'd1;
      r_key_hist <= 1'b1;
      r_load_err <= 1'b0;
      for (int i = 0; i < c_SLOTS; i++) r_cards[i] <= 4'd0;
    end else begin
      r_deal     <= (r_deal == 4'd13) ? 4'd1 : r_deal + 4'd1;
      r_key_hist <= key;
      r_load_err <= w_reject;
      for (int i = 0; i < c_SLOTS; i++) begin
        if (w_write && w_hit[i]) r_cards[i] <= w_val;
      end
    end
  end

  assign load_err = r_load_err;

  for (genvar i = 0; i < c_SLOTS; i++) begin : g_slot
    assign cards_out[4*i +: 4] = r_cards[i];
    assign hex_out[7*i +: 7]   = f_hex(r_cards[i]);
  end

  for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
    logic [6:0] w_sum;
    logic       w_full;
    always_comb begin
      w_sum  = '0;
      w_full = 1'b1;
      for (int s = 0; s < CARDS_PER_HAND; s++) begin
        w_sum  = w_sum + 7'(f_points(r_cards[h*CARDS_PER_HAND + s]));
        w_full = w_full & (r_cards[h*CARDS_PER_HAND + s] != 4'd0);
      end
    end
    assign scores_out[4*h +: 4] = 4'(w_sum % 7'd10);
    assign hand_full[h]         = w_full;
  end

endmodule
`default_nettype wire

// File: tb/tb_baccarat_hand_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_baccarat_hand_bank : scoreboard bench over three bank geometries
// (2x3, 4x5, 3x2) with a card-array reference model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_baccarat_hand_bank;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetb;
  logic [2:0] key;
  logic       load_en;
  logic [2:0] load_hand;
  logic [2:0] load_slot;
  logic       force_en;
  logic [3:0] force_card;

  logic [23:0] cards_a;  logic [7:0]  scores_a; logic [1:0] full_a; logic [41:0]  hex_a; logic err_a;
  logic [79:0] cards_b;  logic [15:0] scores_b; logic [3:0] full_b; logic [139:0] hex_b; logic err_b;
  logic [23:0] cards_c;  logic [11:0] scores_c; logic [2:0] full_c; logic [41:0]  hex_c; logic err_c;

  baccarat_hand_bank #(.NUM_HANDS(2), .CARDS_PER_HAND(3)) dut_a (
    .clk(clk), .resetb(resetb), .key(key[0]), .load_en(load_en),
    .load_hand(load_hand[0:0]), .load_slot(load_slot[1:0]),
    .force_en(force_en), .force_card(force_card),
    .cards_out(cards_a), .scores_out(scores_a), .hand_full(full_a),
    .hex_out(hex_a), .load_err(err_a));

  baccarat_hand_bank #(.NUM_HANDS(4), .CARDS_PER_HAND(5)) dut_b (
    .clk(clk), .resetb(resetb), .key(key[1]), .load_en(load_en),
    .load_hand(load_hand[1:0]), .load_slot(load_slot[2:0]),
    .force_en(force_en), .force_card(force_card),
    .cards_out(cards_b), .scores_out(scores_b), .hand_full(full_b),
    .hex_out(hex_b), .load_err(err_b));

  baccarat_hand_bank #(.NUM_HANDS(3), .CARDS_PER_HAND(2)) dut_c (
    .clk(clk), .resetb(resetb), .key(key[2]), .load_en(load_en),
    .load_hand(load_hand[1:0]), .load_slot(load_slot[0:0]),
    .force_en(force_en), .force_card(force_card),
    .cards_out(cards_c), .scores_out(scores_c), .hand_full(full_c),
    .hex_out(hex_c), .load_err(err_c));

  logic [79:0]  cw [3];
  logic [15:0]  sw [3];
  logic [3:0]   fw [3];
  logic [139:0] xw [3];
  logic         ew [3];
  assign cw[0] = 80'(cards_a);  assign sw[0] = 16'(scores_a); assign fw[0] = 4'(full_a);
  assign xw[0] = 140'(hex_a);   assign ew[0] = err_a;
  assign cw[1] = cards_b;       assign sw[1] = scores_b;       assign fw[1] = full_b;
  assign xw[1] = hex_b;         assign ew[1] = err_b;
  assign cw[2] = 80'(cards_c);  assign sw[2] = 16'(scores_c); assign fw[2] = 4'(full_c);
  assign xw[2] = 140'(hex_c);   assign ew[2] = err_c;

  int NH  [3] = '{2, 4, 3};
  int NS  [3] = '{3, 5, 2};
  int HWB [3] = '{1, 2, 2};
  int SWB [3] = '{2, 3, 1};

  logic [6:0] hex_tbl [14] = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
                               7'b0011000, 7'b0001001};

  int m [3][8][8];
  int cyc = 0;
  int nrst_edges = 0;
  bit done = 1'b0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int           d;
    int           due;
    logic [79:0]  c;
    logic [15:0]  sc;
    logic [3:0]   f;
    logic [139:0] x;
    logic         e;
  } exp_t;
  exp_t q[$];

  // Deal value at the next edge: 1 on the first edge after reset, cycling 1..13
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    nrst_edges <= resetb ? nrst_edges + 1 : 0;
  end

  function automatic exp_t model_snap(int d, int due, bit e);
    exp_t x;
    int   sum, idx, v;
    bit   full;
    x.d = d; x.due = due; x.e = e;
    x.c = '0; x.sc = '0; x.f = '0; x.x = '0;
    for (int h = 0; h < NH[d]; h++) begin
      sum  = 0;
      full = 1'b1;
      for (int s = 0; s < NS[d]; s++) begin
        idx = h * NS[d] + s;
        v   = m[d][h][s];
        x.c[4*idx +: 4] = 4'(v);
        x.x[7*idx +: 7] = hex_tbl[v];
        if (v >= 1 && v <= 9) sum += v;
        if (v == 0) full = 1'b0;
      end
      x.sc[4*h +: 4] = 4'(sum % 10);
      x.f[h]         = full;
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL missed_expect dut%0d due %0d now %0d", q[0].d, q[0].due, cyc);
      void'(q.pop_front());
    end
    for (int d = 0; d < 3; d++) begin
      if (q.size() > 0 && q[0].d == d && q[0].due == cyc) begin
        checks += 5;
        if (cw[d] !== q[0].c) begin errors++;
          $display("FAIL cards dut%0d cyc %0d got %h want %h", d, cyc, cw[d], q[0].c); end
        if (sw[d] !== q[0].sc) begin errors++;
          $display("FAIL scores dut%0d cyc %0d got %h want %h", d, cyc, sw[d], q[0].sc); end
        if (fw[d] !== q[0].f) begin errors++;
          $display("FAIL hand_full dut%0d cyc %0d got %b want %b", d, cyc, fw[d], q[0].f); end
        if (xw[d] !== q[0].x) begin errors++;
          $display("FAIL hex dut%0d cyc %0d got %h want %h", d, cyc, xw[d], q[0].x); end
        if (ew[d] !== q[0].e) begin errors++;
          $display("FAIL load_err dut%0d cyc %0d got %b want %b", d, cyc, ew[d], q[0].e); end
        void'(q.pop_front());
      end else begin
        checks++;
        if (ew[d] !== 1'b0) begin errors++;
          $display("FAIL load_err_idle dut%0d cyc %0d got %b want 0", d, cyc, ew[d]); end
      end
    end
    if (done) begin
      checks++;
      if (q.size() != 0) begin errors++;
        $display("FAIL queue_drain got %0d pending want 0", q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d got timeout want completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_models();
    for (int d = 0; d < 3; d++)
      for (int h = 0; h < 8; h++)
        for (int s = 0; s < 8; s++) m[d][h][s] = 0;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    clear_models();
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
  endtask

  task automatic snap(int d);
    q.push_back(model_snap(d, cyc + 1, 1'b0));
    @(negedge clk);
  endtask

  task automatic press(int d, bit le, int hand, int slot, bit fe, int fc, int hold);
    int h, s, v;
    bit rej;
    h = hand & ((1 << HWB[d]) - 1);
    s = slot & ((1 << SWB[d]) - 1);
    load_en    = le;
    load_hand  = 3'(hand);
    load_slot  = 3'(slot);
    force_en   = fe;
    force_card = 4'(fc);
    key[d]     = 1'b0;
    v   = fe ? (fc & 15) : (nrst_edges % 13) + 1;
    rej = le && (h >= NH[d] || s >= NS[d] || m[d][h][s] != 0 || (fe && (fc == 0 || fc > 13)));
    if (le && !rej) m[d][h][s] = v;
    q.push_back(model_snap(d, cyc + 1, rej));
    repeat (hold) @(negedge clk);
    key[d]  = 1'b1;
    load_en = 1'b0;
    @(negedge clk);
  endtask

  // Reset and press land on the same edge; the reset must win
  task automatic reset_press(int d, int hand, int slot);
    load_en = 1'b1; load_hand = 3'(hand); load_slot = 3'(slot);
    force_en = 1'b1; force_card = 4'd4;
    key[d] = 1'b0; resetb = 1'b0;
    clear_models();
    q.push_back(model_snap(d, cyc + 1, 1'b0));
    @(negedge clk);
    resetb = 1'b1; key[d] = 1'b1; load_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    resetb = 1'b0; key = 3'b111; load_en = 1'b0; load_hand = '0;
    load_slot = '0; force_en = 1'b0; force_card = '0;
    clear_models();
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);

    repeat (20) @(negedge clk);
    snap(0); snap(1); snap(2);

    press(0, 1, 0, 0, 1, 7, 1);
    press(0, 1, 1, 0, 1, 12, 1);
    press(0, 1, 0, 1, 1, 5, 1);

    press(0, 1, 1, 1, 1, 3, 10);
    snap(0);
    press(0, 1, 1, 1, 1, 4, 1);

    press(2, 1, 3, 0, 1, 2, 1);
    press(0, 1, 0, 3, 1, 2, 1);
    press(0, 1, 0, 2, 1, 14, 1);
    press(0, 1, 0, 2, 1, 0, 1);
    press(2, 0, 3, 0, 1, 2, 1);
    press(0, 0, 0, 3, 1, 2, 1);
    press(0, 0, 0, 2, 1, 14, 1);
    press(0, 0, 0, 2, 1, 0, 1);
    press(1, 1, 0, 6, 1, 3, 1);

    do_reset();
    press(0, 1, 0, 0, 1, 9, 1);
    press(0, 1, 0, 1, 1, 9, 1);
    press(0, 1, 0, 2, 1, 9, 1);
    reset_press(0, 1, 0);
    snap(0);

    for (int h = 0; h < 4; h++)
      for (int s = 0; s < 5; s++) begin
        press(1, 1, h, s, 0, 0, int'($urandom_range(1, 3)));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    snap(1);

    for (int n = 0; n < 80; n++) begin
      if (n % 20 == 19) reset_press(2 * int'($urandom_range(0, 1)), 0, 0);
      press(2 * int'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)),
            int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    snap(0); snap(2);

    repeat (2) @(negedge clk);
    done = 1'b1;
  end

endmodule
`default_nettype wire
